// File: rtl/synapse_pkg.sv
// Shared types for the synapse table: slot record, control FSM encoding and
// the saturating weight adder used by the STDP update path.
package synapse_pkg;

    localparam int SYN_NUM_ENTRIES = 16;
    localparam int SYN_ID_W        = 7;
    localparam int SYN_WEIGHT_W    = 9;
    localparam int SYN_W_MAX       = 255;
    localparam int SYN_W_MIN       = -256;

    typedef struct packed {
        logic                           valid;
        logic [SYN_ID_W-1:0]            id;
        logic signed [SYN_WEIGHT_W-1:0] weight;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STDP_RD = 2'd2,
        ST_STDP_WR = 2'd3
    } state_e;

    // One extra bit of headroom so the raw sum never wraps before clamping.
    function automatic logic signed [SYN_WEIGHT_W-1:0] sat_add(
        input logic signed [SYN_WEIGHT_W-1:0] a,
        input logic signed [SYN_WEIGHT_W-1:0] b,
        input int                             lo,
        input int                             hi
    );
        logic signed [SYN_WEIGHT_W:0] sum;
        sum = {a[SYN_WEIGHT_W-1], a} + {b[SYN_WEIGHT_W-1], b};
        if (int'(sum) > hi) begin
            sat_add = SYN_WEIGHT_W'(hi);
        end else if (int'(sum) < lo) begin
            sat_add = SYN_WEIGHT_W'(lo);
        end else begin
            sat_add = sum[SYN_WEIGHT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/synapse_cam_match.sv
// Purpose: NUM_ENTRIES-way ID compare with lowest-index priority select.
// Latency: combinational.
// Backpressure: none; pure function of table contents and key.
module synapse_cam_match #(
    parameter  int NUM_ENTRIES = 16,
    parameter  int ID_W        = 7,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] slot_valid,
    input  logic [ID_W-1:0]        slot_id [NUM_ENTRIES],
    input  logic [ID_W-1:0]        key,
    output logic                   hit,
    output logic [IDX_W-1:0]       slot_idx
);

    // Scanning downwards lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit      = 1'b0;
        slot_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_id[i] == key)) begin
                hit      = 1'b1;
                slot_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/synapse_table.sv
// Purpose: per-neuron synapse store with config writes, spike lookups and saturating STDP updates.
// Latency: lookup result 1 cycle after accept; STDP write lands 2 cycles after accept.
// Backpressure: result held until out_ready; spike/stdp stall outside IDLE, cfg stalls only in STDP states.
module synapse_table
    import synapse_pkg::*;
#(
    parameter  int NUM_ENTRIES = SYN_NUM_ENTRIES,
    parameter  int ID_W        = SYN_ID_W,
    parameter  int WEIGHT_W    = SYN_WEIGHT_W,
    parameter  int W_MAX       = SYN_W_MAX,
    parameter  int W_MIN       = SYN_W_MIN,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                kill,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_slot,
    input  logic [ID_W-1:0]     cfg_id,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                spk_valid,
    output logic                spk_ready,
    input  logic [ID_W-1:0]     spk_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_hit,
    output logic [WEIGHT_W-1:0] out_weight,
    input  logic                stdp_valid,
    output logic                stdp_ready,
    input  logic [ID_W-1:0]     stdp_id,
    input  logic [WEIGHT_W-1:0] stdp_delta
);

    // slot_t carries the package widths, so ID_W/WEIGHT_W track synapse_pkg.
    slot_t                    tbl_q [NUM_ENTRIES];
    state_e                   state_q;
    state_e                   state_d;

    logic                     cfg_acc;
    logic                     spk_acc;
    logic                     stdp_acc;

    logic [NUM_ENTRIES-1:0]   tbl_vld;
    logic [ID_W-1:0]          tbl_id [NUM_ENTRIES];
    logic [ID_W-1:0]          cam_key;
    logic                     cam_hit;
    logic [IDX_W-1:0]         cam_idx;

    logic                     stdp_hit_q;
    logic [IDX_W-1:0]         stdp_idx_q;
    logic signed [WEIGHT_W-1:0] stdp_delta_q;
    logic signed [WEIGHT_W-1:0] stdp_sum_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stdp_acc) begin
                        state_d = ST_STDP_RD;
                    end else if (spk_acc) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STDP_RD: state_d = ST_STDP_WR;
                ST_STDP_WR: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Readies drop during reset and kill so nothing handshakes
    // into a table that is being cleared.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready  = 1'b0;
        spk_ready  = 1'b0;
        stdp_ready = 1'b0;
        out_valid  = (state_q == ST_HOLD);
        if (rst && !kill) begin
            case (state_q)
                ST_IDLE: begin
                    cfg_ready  = 1'b1;
                    stdp_ready = 1'b1;
                    spk_ready  = !stdp_valid;
                end
                ST_HOLD: cfg_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign cfg_acc  = cfg_valid  && cfg_ready;
    assign spk_acc  = spk_valid  && spk_ready;
    assign stdp_acc = stdp_valid && stdp_ready;

    // ------------------------------------------------------------------
    // Shared match: spike and STDP are never accepted in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        tbl_vld = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl_vld[i] = tbl_q[i].valid;
            tbl_id[i]  = tbl_q[i].id;
        end
    end

    assign cam_key = stdp_acc ? stdp_id : spk_id;

    synapse_cam_match #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ID_W        (ID_W)
    ) u_cam (
        .slot_valid (tbl_vld),
        .slot_id    (tbl_id),
        .key        (cam_key),
        .hit        (cam_hit),
        .slot_idx   (cam_idx)
    );

    // ------------------------------------------------------------------
    // Lookup result and STDP pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_hit      <= 1'b0;
            out_weight   <= '0;
            stdp_hit_q   <= 1'b0;
            stdp_idx_q   <= '0;
            stdp_delta_q <= '0;
            stdp_sum_q   <= '0;
        end else begin
            if (spk_acc) begin
                out_hit    <= cam_hit;
                out_weight <= cam_hit ? tbl_q[cam_idx].weight : '0;
            end
            if (stdp_acc) begin
                stdp_hit_q   <= cam_hit;
                stdp_idx_q   <= cam_idx;
                stdp_delta_q <= stdp_delta;
            end
            if (state_q == ST_STDP_RD) begin
                stdp_sum_q <= sat_add(tbl_q[stdp_idx_q].weight, stdp_delta_q, W_MIN, W_MAX);
            end
        end
    end

    // ------------------------------------------------------------------
    // Table storage. The STDP write is ordered after cfg so it lands last.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (kill) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else begin
            if (cfg_acc) begin
                tbl_q[cfg_slot] <= slot_t'{valid: 1'b1, id: cfg_id, weight: cfg_weight};
            end
            if ((state_q == ST_STDP_WR) && stdp_hit_q) begin
                tbl_q[stdp_idx_q].weight <= stdp_sum_q;
            end
        end
    end

endmodule

// File: tb/tb_synapse_table.sv
// Directed and randomized checks of synapse_table against a slot-array reference model.
module tb_synapse_table;

    localparam int NE = 16;
    localparam int IW = 7;
    localparam int WW = 9;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          kill = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [SW-1:0] cfg_slot = '0;
    logic [IW-1:0] cfg_id = '0;
    logic [WW-1:0] cfg_weight = '0;
    logic          spk_valid = 1'b0;
    logic          spk_ready;
    logic [IW-1:0] spk_id = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_hit;
    logic [WW-1:0] out_weight;
    logic          stdp_valid = 1'b0;
    logic          stdp_ready;
    logic [IW-1:0] stdp_id = '0;
    logic [WW-1:0] stdp_delta = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer view of each slot.
    bit mvalid [NE];
    int mid    [NE];
    int mw     [NE];

    synapse_table dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_slot   (cfg_slot),
        .cfg_id     (cfg_id),
        .cfg_weight (cfg_weight),
        .spk_valid  (spk_valid),
        .spk_ready  (spk_ready),
        .spk_id     (spk_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .out_weight (out_weight),
        .stdp_valid (stdp_valid),
        .stdp_ready (stdp_ready),
        .stdp_id    (stdp_id),
        .stdp_delta (stdp_delta)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            mvalid[i] = 1'b0;
            mid[i]    = 0;
            mw[i]     = 0;
        end
    endtask

    task automatic model_lookup(input int id, output int hit, output int w);
        hit = 0;
        w   = 0;
        for (int i = 0; i < NE; i++) begin
            if (mvalid[i] && mid[i] == id) begin
                hit = 1;
                w   = mw[i];
                break;
            end
        end
    endtask

    task automatic model_stdp(input int id, input int delta);
        for (int i = 0; i < NE; i++) begin
            if (mvalid[i] && mid[i] == id) begin
                mw[i] = clamp(mw[i] + delta);
                break;
            end
        end
    endtask

    function automatic int wout();
        return int'($signed(out_weight));
    endfunction

    task automatic cfg_write(input int slot, input int id, input int w, input string tag);
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_slot   = SW'(slot);
        cfg_id     = IW'(id);
        cfg_weight = WW'(w);
        #1;
        chk({tag, "_cfg_rdy"}, int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        mvalid[slot] = 1'b1;
        mid[slot]    = id;
        mw[slot]     = w;
    endtask

    task automatic issue_spike(input int id, input string tag);
        int k;
        @(negedge clk);
        spk_valid = 1'b1;
        spk_id    = IW'(id);
        #1;
        k = 0;
        while (!spk_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_spk_rdy"}, int'(spk_ready), 1);
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
    endtask

    task automatic check_result(input int hit, input int w, input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_out_hit"}, int'(out_hit), hit);
        chk({tag, "_out_weight"}, wout(), w);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_out_drop"}, int'(out_valid), 0);
    endtask

    task automatic lookup_model(input int id, input string tag);
        int h, w;
        model_lookup(id, h, w);
        issue_spike(id, tag);
        check_result(h, w, tag);
        consume(tag);
    endtask

    task automatic lookup_const(input int id, input int hit, input int w, input string tag);
        issue_spike(id, tag);
        check_result(hit, w, tag);
        consume(tag);
    endtask

    task automatic do_stdp(input int id, input int delta, input string tag);
        int k;
        @(negedge clk);
        stdp_valid = 1'b1;
        stdp_id    = IW'(id);
        stdp_delta = WW'(delta);
        #1;
        k = 0;
        while (!stdp_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_stdp_rdy"}, int'(stdp_ready), 1);
        @(posedge clk);
        #1;
        stdp_valid = 1'b0;
        chk({tag, "_busy1"}, int'(stdp_ready | spk_ready), 0);
        @(posedge clk);
        #1;
        chk({tag, "_busy2"}, int'(stdp_ready | spk_ready), 0);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, int'(stdp_ready), 1);
        model_stdp(id, delta);
    endtask

    task automatic do_kill();
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        for (int i = 0; i < NE; i++) mvalid[i] = 1'b0;
    endtask

    initial begin
        int k;
        model_reset();

        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_hit", int'(out_hit), 0);
        chk("rst_out_weight", wout(), 0);
        chk("rst_cfg_rdy", int'(cfg_ready), 0);
        chk("rst_spk_rdy", int'(spk_ready), 0);
        chk("rst_stdp_rdy", int'(stdp_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_cfg_rdy", int'(cfg_ready), 1);
        chk("rel_spk_rdy", int'(spk_ready), 1);
        lookup_const(8'h15, 0, 0, "rel_miss");

        // Basic load, lookup, hold stability, miss
        cfg_write(3, 8'h15, 40, "t2");
        issue_spike(8'h15, "t2_hit");
        check_result(1, 40, "t2_hit");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_result(1, 40, $sformatf("t2_hold%0d", c));
        end
        consume("t2_hit");
        lookup_const(8'h16, 0, 0, "t2_miss");

        // Saturating STDP
        cfg_write(0, 8'h20, 250, "t3a");
        cfg_write(1, 8'h21, -250, "t3b");
        do_stdp(8'h20, 20, "t3a");
        lookup_const(8'h20, 1, 255, "t3a_sat_hi");
        do_stdp(8'h21, -20, "t3b");
        lookup_const(8'h21, 1, -256, "t3b_sat_lo");
        do_stdp(8'h15, -5, "t3c");
        lookup_const(8'h15, 1, 35, "t3c_plain");
        do_stdp(8'h7f, 3, "t3d_miss");
        lookup_const(8'h15, 1, 35, "t3d_nochange");

        // Duplicate IDs: lowest index wins for lookup and update
        cfg_write(2, 8'h09, 7, "t4a");
        cfg_write(5, 8'h09, 99, "t4b");
        lookup_const(8'h09, 1, 7, "t4_prio");
        do_stdp(8'h09, 1, "t4");
        lookup_const(8'h09, 1, 8, "t4_upd");
        cfg_write(2, 8'h0a, 8, "t4c");
        lookup_const(8'h09, 1, 99, "t4_slot5");

        // STDP and spike in the same cycle
        @(negedge clk);
        stdp_valid = 1'b1;
        stdp_id    = IW'(8'h15);
        stdp_delta = WW'(10);
        spk_valid  = 1'b1;
        spk_id     = IW'(8'h15);
        #1;
        chk("t5_stdp_rdy", int'(stdp_ready), 1);
        chk("t5_spk_blocked", int'(spk_ready), 0);
        @(posedge clk);
        #1;
        stdp_valid = 1'b0;
        model_stdp(8'h15, 10);
        chk("t5_spk_wait", int'(spk_ready), 0);
        k = 0;
        while (!spk_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t5_spk_rdy", int'(spk_ready), 1);
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        check_result(1, 45, "t5_new_w");
        consume("t5");

        // Kill during HOLD, with a cfg write that must be ignored
        issue_spike(8'h15, "t6");
        check_result(1, 45, "t6_pre");
        @(negedge clk);
        kill       = 1'b1;
        cfg_valid  = 1'b1;
        cfg_slot   = SW'(7);
        cfg_id     = IW'(8'h30);
        cfg_weight = WW'(5);
        #1;
        chk("t6_cfg_blocked", int'(cfg_ready), 0);
        @(posedge clk);
        #1;
        kill      = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < NE; i++) mvalid[i] = 1'b0;
        chk("t6_out_drop", int'(out_valid), 0);
        lookup_const(8'h30, 0, 0, "t6_cfg_ign");
        lookup_const(8'h15, 0, 0, "t6_miss15");
        lookup_const(8'h09, 0, 0, "t6_miss09");

        // Reset mid-HOLD
        cfg_write(4, 8'h11, 77, "t1");
        issue_spike(8'h11, "t1");
        check_result(1, 77, "t1_pre");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t1_out_valid", int'(out_valid), 0);
        chk("t1_out_weight", wout(), 0);
        chk("t1_spk_rdy", int'(spk_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_cfg_rdy", int'(cfg_ready), 1);
        chk("t1_stdp_rdy", int'(stdp_ready), 1);
        lookup_const(8'h11, 0, 0, "t1_miss11");
        lookup_const(8'h20, 0, 0, "t1_miss20");

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op, id, slot, w, h, ew;
            op   = $urandom_range(0, 19);
            id   = $urandom_range(0, 5);
            slot = $urandom_range(0, NE - 1);
            w    = int'($urandom_range(0, 511)) - 256;
            if (op < 6) begin
                cfg_write(slot, id, w, "rnd_cfg");
            end else if (op < 11) begin
                lookup_model(id, "rnd_spk");
            end else if (op < 16) begin
                do_stdp(id, w, "rnd_stdp");
            end else if (op < 19) begin
                model_lookup(id, h, ew);
                issue_spike(id, "rnd_hold");
                cfg_write(slot, $urandom_range(0, 5), int'($urandom_range(0, 511)) - 256, "rnd_hcfg");
                check_result(h, ew, "rnd_hold");
                consume("rnd_hold");
            end else begin
                do_kill();
            end
        end
        for (int id = 0; id < 6; id++) lookup_model(id, "rnd_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
